// File: rtl/pe_net_rx_if.sv
// ---------------------------------------------------------------------------
// pe_net_rx_if
// Bundles the two handshakes of the PE-side network receive block:
//   sReq / sAck / sData        : router-to-PE word transfer (Req/Ack)
//   rdEn / rdData / rdValid /
//   rdLast                     : first-word-fall-through read port toward
//                                the processor bus logic
// modport slave  : used by pe_net_rx (consumes words, serves reads)
// modport master : used by whoever drives words in and pops words out
// ---------------------------------------------------------------------------
interface pe_net_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sReq;
  logic                  sAck;
  logic [DATA_WIDTH-1:0] sData;
  logic                  rdEn;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;
  logic                  rdLast;

  modport master (
    output sReq, sData, rdEn,
    input  sAck, rdData, rdValid, rdLast
  );

  modport slave (
    input  sReq, sData, rdEn,
    output sAck, rdData, rdValid, rdLast
  );
endinterface

// File: rtl/pe_net_rx.sv
// ---------------------------------------------------------------------------
// pe_net_rx
// Receiving end of the router's PE master port. Words arrive over a Req/Ack
// handshake; the header destination is checked against this node's (X,Y).
// Packets addressed here are stored whole in a word FIFO, misaddressed
// packets are acked and discarded. Only completed packets are offered on the
// first-word-fall-through read port.
// Ports:
//   clk_i        : clock (HCLK)
//   rst_ni       : asynchronous active-low reset
//   bus          : pe_net_rx_if.slave (sReq/sAck/sData, rdEn/rdData/
//                  rdValid/rdLast)
//   pktCount_o   : number of complete packets buffered
//   dropCount_o  : saturating count of misaddressed packets
// ---------------------------------------------------------------------------
module pe_net_rx #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PACKET_LEN = 8,
  parameter int NET_ADDR       = 4,
  parameter int ADDRX          = 0,
  parameter int ADDRY          = 0,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  pe_net_rx_if.slave                      bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pktCount_o,
  output logic [7:0]                      dropCount_o
);

  localparam int LW = $clog2(MAX_PACKET_LEN);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {HDR, PAY, DROP} state_e;

  state_e                state_q;
  logic [LW-1:0]         remain_q;
  logic                  sAck_q;
  logic [7:0]            dropCount_q;
  logic [PW-1:0]         wrPtr_q;
  logic [PW-1:0]         rdPtr_q;
  logic [CW-1:0]         occ_q;
  logic [CW-1:0]         occ_d;
  logic [CW-1:0]         pktCount_q;
  logic [CW-1:0]         pktCount_d;
  logic [LW-1:0]         rdCnt_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                  hdrMatch;
  logic [LW-1:0]         hdrLen;
  logic                  roomOk;
  logic                  capture;
  logic                  wrEn;
  logic                  pktDone;
  logic [DATA_WIDTH-1:0] headWord;
  logic [LW-1:0]         headLen;
  logic                  rdValid;
  logic                  rdLast;
  logic                  popEn;

  // Header decode of the word currently offered by the router.
  assign hdrLen   = bus.sData[16 +: LW];
  assign hdrMatch = (bus.sData[NET_ADDR-1:0] == NET_ADDR'(ADDRX)) &&
                    (bus.sData[2*NET_ADDR-1:NET_ADDR] == NET_ADDR'(ADDRY));

  // A word is taken only when the previous ack pulse is over; words being
  // discarded never need FIFO room, so DROP ignores occupancy. Occupancy is
  // the registered value, so a pop this cycle frees space only next cycle.
  assign roomOk  = (state_q == DROP) || (occ_q < CW'(FIFO_DEPTH));
  assign capture = bus.sReq && !sAck_q && roomOk;
  assign wrEn    = capture && (((state_q == HDR) && hdrMatch) || (state_q == PAY));
  assign pktDone = capture &&
                   (((state_q == HDR) && hdrMatch && (hdrLen == '0)) ||
                    ((state_q == PAY) && (remain_q == LW'(1))));

  // Read side: a zero read counter means the head word is a header.
  assign headWord = mem[rdPtr_q];
  assign headLen  = headWord[16 +: LW];
  assign rdValid  = (pktCount_q != '0);
  assign rdLast   = rdValid && ((rdCnt_q == '0) ? (headLen == '0) : (rdCnt_q == LW'(1)));
  assign popEn    = bus.rdEn && rdValid;

  assign bus.sAck    = sAck_q;
  assign bus.rdData  = headWord;
  assign bus.rdValid = rdValid;
  assign bus.rdLast  = rdLast;
  assign pktCount_o  = pktCount_q;
  assign dropCount_o = dropCount_q;

  // Next occupancy and packet count; a simultaneous increment and decrement
  // cancel out.
  always_comb begin
    occ_d      = occ_q;
    pktCount_d = pktCount_q;
    case ({wrEn, popEn})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    case ({pktDone, popEn && rdLast})
      2'b10:   pktCount_d = pktCount_q + CW'(1);
      2'b01:   pktCount_d = pktCount_q - CW'(1);
      default: pktCount_d = pktCount_q;
    endcase
  end

  // Write-side packet parser: the ack pulse follows each capture by one
  // cycle; headers decide keep/discard and how many payload words follow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HDR;
      remain_q    <= '0;
      sAck_q      <= 1'b0;
      dropCount_q <= '0;
      wrPtr_q     <= '0;
    end else begin
      sAck_q <= capture;
      if (wrEn) wrPtr_q <= wrPtr_q + PW'(1);
      if (capture) begin
        unique case (state_q)
          HDR: begin
            if (!hdrMatch && (dropCount_q != 8'hFF)) dropCount_q <= dropCount_q + 8'd1;
            if (hdrLen != '0) begin
              remain_q <= hdrLen;
              state_q  <= hdrMatch ? PAY : DROP;
            end
          end
          PAY, DROP: begin
            remain_q <= remain_q - LW'(1);
            if (remain_q == LW'(1)) state_q <= HDR;
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy guards them.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem[wrPtr_q] <= bus.sData;
  end

  // Read pointer, per-packet read counter, occupancy and packet count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q    <= '0;
      rdCnt_q    <= '0;
      occ_q      <= '0;
      pktCount_q <= '0;
    end else begin
      occ_q      <= occ_d;
      pktCount_q <= pktCount_d;
      if (popEn) begin
        rdPtr_q <= rdPtr_q + PW'(1);
        rdCnt_q <= (rdCnt_q == '0) ? headLen : (rdCnt_q - LW'(1));
      end
    end
  end

endmodule

// File: doc/pe_net_rx.md
Name: pe_net_rx

Overview:
- PE-side network receive interface: the receiving end of the router's PE master port (M_Req_PE/M_Ack_PE/M_Data_PE).
- Accepts packets word-by-word over the Req/Ack handshake, checks the header destination against the node address, and buffers whole packets in a word FIFO.
- Presents completed packets to the processor bus logic as a first-word-fall-through read port.
- Sits inside soc beside the transmit path, clocked by HCLK.

Parameters:
DATA_WIDTH, 32, word width of network data and FIFO entries
MAX_PACKET_LEN, 8, max packet words including header; length field width LW = $clog2(MAX_PACKET_LEN)
NET_ADDR, 4, bits per X/Y coordinate in header
ADDRX, 0, this node's X coordinate
ADDRY, 0, this node's Y coordinate
FIFO_DEPTH, 16, word FIFO entries; power of two, >= MAX_PACKET_LEN

Ports:
Clock  in  1  single clock
nReset  in  1  asynchronous active-low reset
S_Req  in  1  router asserts: S_Data valid
S_Ack  out  1  registered one-cycle accept pulse
S_Data  in  DATA_WIDTH  packet word from router
Rd_En  in  1  pop head word
Rd_Data  out  DATA_WIDTH  head FIFO word (FWFT)
Rd_Valid  out  1  at least one complete packet buffered
Rd_Last  out  1  Rd_Data is the last word of its packet
Pkt_Count  out  $clog2(FIFO_DEPTH+1)  complete packets buffered
Drop_Count  out  8  saturating count of misaddressed packets

Behaviour:
- Reset (async, nReset=0): S_Ack=0, FIFO empty, Rd_Valid=0, Rd_Last=0, Pkt_Count=0, Drop_Count=0, FSM=HDR, read-side counter=0. Rd_Data is don't-care while empty.
- Header format: [NET_ADDR-1:0] dest X; [2*NET_ADDR-1:NET_ADDR] dest Y; [4*NET_ADDR-1:2*NET_ADDR] src X/Y; [16+LW-1:16] payload length L (0..MAX_PACKET_LEN-1). Other bits are stored unchanged.
- Handshake:
  - Capture at a rising edge when S_Req=1 && S_Ack=0 && capture permitted.
  - S_Ack is 1 in the following cycle only.
  - Sender holds S_Data until it sees S_Ack=1, then presents the next word or drops S_Req.
  - Words present while S_Ack=1 are ignored.
  - Max rate is one word per 2 cycles.
- Capture permitted: in HDR/PAY when FIFO occupancy (registered) < FIFO_DEPTH; always in DROP. A pop in the same cycle does not create space that cycle.
- FSM:
  - HDR: on capture, if dest==(ADDRX,ADDRY):
    - write header;
    - if L==0, Pkt_Count+1 and stay in HDR;
    - else load remaining=L and go to PAY.
  - HDR, dest mismatch: Drop_Count+1 (saturating at 255); if L==0 stay in HDR, else remaining=L and go to DROP.
  - PAY: each capture writes the word and decrements remaining; on the capture where remaining==1, Pkt_Count+1 and go to HDR.
  - DROP: each capture is acked and discarded and decrements remaining; remaining==1 returns to HDR.
- Read side:
  - Rd_Valid = (Pkt_Count != 0).
  - Rd_En is ignored when Rd_Valid=0.
  - Rd_En pops exactly one word per cycle.
  - When the popped word is a header, the read counter loads L.
  - Each popped payload word decrements the read counter.
  - Rd_Last = Rd_Valid && (head is header with L==0, or read counter==1).
  - Popping the word with Rd_Last=1 decrements Pkt_Count.
- Simultaneous packet completion (write side) and last-word pop (read side): Pkt_Count unchanged.
- A partial packet in the FIFO never raises Rd_Valid; words from a later packet are never readable before the current packet completes.
- Reset mid-packet discards all state; the sender's recovery is outside this block.

Test Plan:
- ADDRX=1, ADDRY=2. Send header 0x0003_0021 plus payload 0xA, 0xB, 0xC. Required:
  - S_Ack pulses 4 times, each one cycle after a capture, never two cycles in a row.
  - Pkt_Count goes 0→1 after the 4th word, not earlier.
  - Popping returns 0x0003_0021, 0xA, 0xB, 0xC with Rd_Last=1 only on 0xC; Pkt_Count then reads 0.
- Send header 0x0000_0021 (L=0) -> Pkt_Count=1, Rd_Data=0x0000_0021 with Rd_Last=1; one pop returns Pkt_Count to 0.
- Send header 0x0002_0013 (dest 3,1) plus 2 payload words, then a valid 1-word-payload packet. Required:
  - all 5 words acked;
  - Drop_Count=1;
  - only the second packet is buffered (2 words, Pkt_Count=1).
- Stream two 7-word-payload packets (16 words) with Rd_En=0 and FIFO_DEPTH=16 -> all accepted, Pkt_Count=2.
  - A 17th word is held unacked with S_Req=1 until one pop; it is acked 2 cycles after the pop at the earliest.
- Rd_En asserted continuously while a 3-word packet is still arriving -> no pop and Rd_Valid=0 until the last word is captured.
  - Pop the final word of packet 1 on the same edge packet 2 completes -> Pkt_Count stays 1.
- Assert nReset=0 mid-payload (remaining=2) -> outputs take reset values immediately.
  - After release, a fresh header is parsed as a header (FSM=HDR) and Pkt_Count=0.
